// File: rtl/tsu_pkg.sv
// Shared constants, FSM encodings and FIFO entry layout for the PTP ingress time-stamp unit.
// The optional ingress latency compensation is enabled by defining TSU_LAT_COMP_EN.
package tsu_pkg;

  localparam int TS_SEC_W = 48;
  localparam int TS_NS_W  = 32;
  localparam int TS_W     = TS_SEC_W + TS_NS_W;
  localparam int ENTRY_W  = 128;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
  localparam logic [7:0]  PREAMBLE   = 8'h55;
  localparam logic [7:0]  SFD        = 8'hD5;

  // Bit offsets of the fields inside a 128-bit FIFO entry.
  localparam int INFOR_LSB = 0;
  localparam int NS_LSB    = 32;
  localparam int SEC_LSB   = 64;
  localparam int CH_LSB    = 112;

  typedef enum logic [1:0] {
    SFD_IDLE = 2'd0,
    SFD_PRE  = 2'd1,
    SFD_DATA = 2'd2,
    SFD_SKIP = 2'd3
  } sfd_state_e;

  typedef struct packed {
    logic [7:0]          rsvd;
    logic [7:0]          ch_id;
    logic [TS_SEC_W-1:0] sec;
    logic [TS_NS_W-1:0]  ns;
    logic [31:0]         infor;
  } entry_t;

  // Adds a nanosecond offset to a {sec, ns} stamp, carrying into seconds at one second.
  function automatic logic [TS_W-1:0] ts_add_ns(input logic [TS_W-1:0] ts,
                                                input logic [31:0]     add);
    logic [32:0]         sum;
    logic [TS_SEC_W-1:0] sec;
    sum = {1'b0, ts[TS_NS_W-1:0]} + {1'b0, add};
    sec = ts[TS_W-1:TS_NS_W];
    if (sum >= {1'b0, NS_PER_SEC}) begin
      sum = sum - {1'b0, NS_PER_SEC};
      sec = sec + 48'd1;
    end
    return {sec, sum[31:0]};
  endfunction

endpackage

// File: rtl/tsu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags and an occupancy count.
// Write and read handshake: a beat moves when its enable is high and the FIFO is not full/empty.
module tsu_sync_fifo
  import tsu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  // Head is shown combinationally; gated so the bus reads zero while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tsu_mc_stamper.sv
// Multi-channel PTP ingress time-stamp unit: per-channel SFD detection and capture, RR merge
// into one shared FIFO. Define TSU_LAT_COMP_EN to add per-channel ingress latency to stamps.
// CPU side: q_rd_data is valid whenever q_rd_empty is low; q_rd_en pops it on the next edge.
module tsu_mc_stamper
  import tsu_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int LAT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       rx_valid,
  input  logic [NCH-1:0]       rx_ctrl,
  input  logic [8*NCH-1:0]     rx_data,
  input  logic [TS_W-1:0]      rtc_time,
  input  logic [NCH-1:0]       ptp_done,
  input  logic [NCH-1:0]       ptp_found,
  input  logic [32*NCH-1:0]    ptp_infor,
  input  logic [LAT_W*NCH-1:0] lat_ns,
  input  logic                 q_rd_en,
  output logic [ENTRY_W-1:0]   q_rd_data,
  output logic                 q_rd_empty,
  output logic [AW:0]          q_rd_stat,
  output logic [15:0]          drop_cnt
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] pend_vld;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] drop_evt;
  entry_t         pend_data [NCH];
  logic           grant_any;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  last_grant;
  logic           fifo_full;
  int             rr_c;
  logic [4:0]     drop_inc;
  logic [16:0]    drop_sum;

`ifndef TSU_LAT_COMP_EN
  logic lat_unused;
  assign lat_unused = ^lat_ns;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sfd_state_e      state_q, state_d;
    logic            hit;
    logic [7:0]      byte_i;
    logic            set_cap;
    logic [TS_W-1:0] new_ts;
    logic            cap_vld_q;
    logic [TS_W-1:0] cap_ts_q;
    logic            pend_vld_q;
    entry_t          pend_q;
    logic            commit;
    logic            can_load;

    assign byte_i = rx_data[8*i +: 8];

    always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      if (rx_valid[i]) begin
        unique case (state_q)
          SFD_IDLE: if (rx_ctrl[i]) state_d = (byte_i == PREAMBLE) ? SFD_PRE : SFD_SKIP;
          SFD_PRE: begin
            if (!rx_ctrl[i])              state_d = SFD_IDLE;
            else if (byte_i == PREAMBLE)  state_d = SFD_PRE;
            else if (byte_i == SFD) begin
              state_d = SFD_DATA;
              hit     = 1'b1;
            end else                      state_d = SFD_SKIP;
          end
          default:  if (!rx_ctrl[i]) state_d = SFD_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) state_q <= SFD_IDLE;
      else        state_q <= state_d;
    end

`ifdef TSU_LAT_COMP_EN
    // Raw stamp is registered first; the latency-corrected value lands one cycle later.
    logic            hit_q;
    logic [TS_W-1:0] raw_ts_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hit_q    <= 1'b0;
        raw_ts_q <= '0;
      end else begin
        hit_q <= hit;
        if (hit) raw_ts_q <= rtc_time;
      end
    end
    assign set_cap = hit_q;
    assign new_ts  = ts_add_ns(raw_ts_q, 32'(lat_ns[LAT_W*i +: LAT_W]));
`else
    assign set_cap = hit;
    assign new_ts  = rtc_time;
`endif

    assign commit      = ptp_done[i] & ptp_found[i] & cap_vld_q;
    assign can_load    = ~pend_vld_q | grant_oh[i];
    assign drop_evt[i] = commit & ~can_load;

    // ptp_done consumes the old capture; a capture in the same cycle re-arms it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cap_vld_q  <= 1'b0;
        cap_ts_q   <= '0;
        pend_vld_q <= 1'b0;
        pend_q     <= '0;
      end else begin
        if (ptp_done[i]) cap_vld_q <= 1'b0;
        if (set_cap) begin
          cap_vld_q <= 1'b1;
          cap_ts_q  <= new_ts;
        end
        if (commit && can_load) begin
          pend_vld_q <= 1'b1;
          pend_q     <= {8'd0, 8'(i), cap_ts_q, ptp_infor[32*i +: 32]};
        end else if (grant_oh[i]) begin
          pend_vld_q <= 1'b0;
        end
      end
    end

    assign pend_vld[i]  = pend_vld_q;
    assign pend_data[i] = pend_q;
  end

  // Round-robin: search from the channel after the last winner; no grant while full.
  always_comb begin
    grant_oh  = '0;
    grant_idx = last_grant;
    grant_any = 1'b0;
    rr_c      = 0;
    if (!fifo_full) begin
      for (int k = 1; k <= NCH; k++) begin
        rr_c = (int'(last_grant) + k) % NCH;
        if (!grant_any && pend_vld[rr_c]) begin
          grant_any = 1'b1;
          grant_idx = CW'(rr_c);
        end
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    drop_inc = '0;
    for (int k = 0; k < NCH; k++) drop_inc = drop_inc + 5'(drop_evt[k]);
    drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= '0;
      drop_cnt   <= '0;
    end else begin
      if (grant_any) last_grant <= grant_idx;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  tsu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (grant_any),
    .wr_data (pend_data[grant_idx]),
    .rd_en   (q_rd_en),
    .rd_data (q_rd_data),
    .empty   (q_rd_empty),
    .full    (fifo_full),
    .count   (q_rd_stat)
  );

endmodule

// File: tb/tb_tsu_mc_stamper.sv
// Directed bench for tsu_mc_stamper: expected FIFO entries queued at ptp_done, checked at pop.
module tb_tsu_mc_stamper;

  logic          clk;
  logic          rst_n;
  logic [3:0]    rx_valid;
  logic [3:0]    rx_ctrl;
  logic [31:0]   rx_data;
  logic [79:0]   rtc_time;
  logic [3:0]    ptp_done;
  logic [3:0]    ptp_found;
  logic [127:0]  ptp_infor;
  logic [63:0]   lat_ns;
  logic          q_rd_en;
  logic [127:0]  q_rd_data;
  logic          q_rd_empty;
  logic [4:0]    q_rd_stat;
  logic [15:0]   drop_cnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            mdl_last = 0;
  logic [127:0]  exp_q[$];

  tsu_mc_stamper #(.NCH(4), .DEPTH(16), .LAT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_ctrl    (rx_ctrl),
    .rx_data    (rx_data),
    .rtc_time   (rtc_time),
    .ptp_done   (ptp_done),
    .ptp_found  (ptp_found),
    .ptp_infor  (ptp_infor),
    .lat_ns     (lat_ns),
    .q_rd_en    (q_rd_en),
    .q_rd_data  (q_rd_data),
    .q_rd_empty (q_rd_empty),
    .q_rd_stat  (q_rd_stat),
    .drop_cnt   (drop_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int ch, input logic c, input logic [7:0] d);
    rx_valid[ch]       = 1'b1;
    rx_ctrl[ch]        = c;
    rx_data[8*ch +: 8] = d;
  endtask

  task automatic drive_byte(input int ch, input logic c, input logic [7:0] d,
                            input logic [79:0] rtc);
    rx_valid = '0;
    set_byte(ch, c, d);
    rtc_time = rtc;
    step();
  endtask

  function automatic logic [79:0] rand_rtc();
    return {16'h0, 32'($urandom), 32'($urandom_range(0, 999_999_999))};
  endfunction

  // 7x55, D5 (stamped at {sec,ns}), two data bytes, ctrl drop; then ptp_done on every masked ch.
  task automatic run_frame(input logic [3:0] mask, input logic [47:0] sec, input logic [31:0] ns,
                           input logic [31:0] inf_base, input logic found, input logic expect_entry);
    int start;
    for (int b = 0; b < 11; b++) begin
      rx_valid = '0;
      rtc_time = (b == 7) ? {sec, ns} : rand_rtc();
      for (int c = 0; c < 4; c++) begin
        if (mask[c]) begin
          if (b < 7)       set_byte(c, 1'b1, 8'h55);
          else if (b == 7) set_byte(c, 1'b1, 8'hD5);
          else if (b < 10) set_byte(c, 1'b1, 8'($urandom_range(0, 255)));
          else             set_byte(c, 1'b0, 8'h00);
        end
      end
      step();
    end
    rx_valid = '0;
    rx_ctrl  = '0;
    for (int c = 0; c < 4; c++) ptp_infor[32*c +: 32] = inf_base + 32'(c);
    ptp_done  = mask;
    ptp_found = found ? mask : 4'h0;
    if (found && expect_entry) begin
      start = mdl_last;
      for (int k = 1; k <= 4; k++) begin
        if (mask[(start + k) % 4]) begin
          exp_q.push_back({8'd0, 8'((start + k) % 4), sec, ns, inf_base + 32'((start + k) % 4)});
          mdl_last = (start + k) % 4;
        end
      end
    end
    step();
    ptp_done  = '0;
    ptp_found = '0;
  endtask

  // Scoreboard: wait (bounded) for a head entry, compare with the queue front, then pop it.
  task automatic pop_check(input string tag);
    logic [127:0] e;
    int w;
    w = 0;
    while (q_rd_empty && w < 20) begin
      step();
      w++;
    end
    check({tag, "_avail"}, 128'(q_rd_empty), 128'(1'b0));
    if (!q_rd_empty) begin
      e = exp_q.pop_front();
      check(tag, q_rd_data, e);
      q_rd_en = 1'b1;
      step();
      q_rd_en = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_check(tag);
    step();
    check({tag, "_empty"}, 128'(q_rd_empty), 128'(1'b1));
    check({tag, "_stat0"}, 128'(q_rd_stat), 128'(5'd0));
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_valid  = '0;
    rx_ctrl   = '0;
    rx_data   = '0;
    rtc_time  = '0;
    ptp_done  = '0;
    ptp_found = '0;
    ptp_infor = '0;
    lat_ns    = '0;
    q_rd_en   = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_data",  q_rd_data, 128'd0);
    check("rst_empty", 128'(q_rd_empty), 128'(1'b1));
    check("rst_stat",  128'(q_rd_stat), 128'(5'd0));
    check("rst_drop",  128'(drop_cnt), 128'(16'd0));
    rst_n = 1'b1;
    step();

    // Single stamped frame on ch2
    run_frame(4'b0100, 48'h10, 32'd500, 32'h1ABC0040, 1'b1, 1'b1);
`ifndef TSU_LAT_COMP_EN
    check("t1_lat1_empty", 128'(q_rd_empty), 128'(1'b1));
    step();
    check("t1_lat2_ready", 128'(q_rd_empty), 128'(1'b0));
`endif
    check("t1_head", q_rd_data, 128'h0002_0000_0000_0010_0000_01F4_1ABC_0042);
    check("t1_stat", 128'(q_rd_stat), 128'(5'd1));
    drain("t1_pop");

    // Round-robin: move last grant to ch1, then all four commit together
    run_frame(4'b0010, 48'h22, 32'd1234, $urandom, 1'b1, 1'b1);
    drain("t2_pre");
    run_frame(4'b1111, 48'h3456, 32'd777, $urandom, 1'b1, 1'b1);
    step(); step(); step();
    check("t2_stat3", 128'(q_rd_stat), 128'(5'd3));
    step();
    check("t2_stat4", 128'(q_rd_stat), 128'(5'd4));
    check("t2_head_ch2", 128'(q_rd_data[119:112]), 128'(8'd2));
    drain("t2_order");

    // Fill the FIFO, hold a pending ch0 entry, then lose a second ch0 entry
    for (int r = 0; r < 4; r++)
      run_frame(4'b1111, 48'(r + 100), 32'($urandom_range(0, 999_999_999)), $urandom, 1'b1, 1'b1);
    repeat (6) step();
    check("t3_full_stat", 128'(q_rd_stat), 128'(5'd16));
    run_frame(4'b0001, 48'hABC, 32'd42, $urandom, 1'b1, 1'b1);
    run_frame(4'b0001, 48'hDEF, 32'd43, $urandom, 1'b1, 1'b0);
    check("t3_drop1", 128'(drop_cnt), 128'(16'd1));
    check("t3_still_full", 128'(q_rd_stat), 128'(5'd16));
    pop_check("t3_first");
    step(); step();
    check("t3_pend_written", 128'(q_rd_stat), 128'(5'd16));
    drain("t3_rest");
    check("t3_drop_hold", 128'(drop_cnt), 128'(16'd1));

    // Corrupt preamble: 55,55,AA,D5 never captures; a not-found verdict commits nothing
    drive_byte(3, 1'b1, 8'h55, rand_rtc());
    drive_byte(3, 1'b1, 8'h55, rand_rtc());
    drive_byte(3, 1'b1, 8'hAA, rand_rtc());
    drive_byte(3, 1'b1, 8'hD5, rand_rtc());
    drive_byte(3, 1'b1, 8'h11, rand_rtc());
    drive_byte(3, 1'b0, 8'h00, rand_rtc());
    rx_valid  = '0;
    ptp_done  = 4'b1000;
    ptp_found = 4'b1000;
    step();
    ptp_done  = '0;
    ptp_found = '0;
    run_frame(4'b0100, 48'h77, 32'd88, $urandom, 1'b0, 1'b0);
    repeat (5) step();
    check("t4_empty", 128'(q_rd_empty), 128'(1'b1));
    check("t4_stat",  128'(q_rd_stat), 128'(5'd0));
    check("t4_drop",  128'(drop_cnt), 128'(16'd1));

`ifdef TSU_LAT_COMP_EN
    // Latency compensation across a second boundary
    lat_ns[16*1 +: 16] = 16'd25;
    run_frame(4'b0010, 48'd5, 32'd999_999_990, 32'h0BAD_F00D, 1'b1, 1'b0);
    exp_q.push_back({8'd0, 8'd1, 48'd6, 32'd15, 32'h0BAD_F00E});
    mdl_last = 1;
    drain("t5_latcomp");
    lat_ns = '0;
`endif

    // Reset in the middle of a ch1 preamble
    for (int b = 0; b < 3; b++) drive_byte(1, 1'b1, 8'h55, rand_rtc());
    rst_n = 1'b0;
    for (int b = 0; b < 4; b++) drive_byte(1, 1'b1, 8'h55, rand_rtc());
    check("t6_rst_empty", 128'(q_rd_empty), 128'(1'b1));
    check("t6_rst_stat",  128'(q_rd_stat), 128'(5'd0));
    check("t6_rst_drop",  128'(drop_cnt), 128'(16'd0));
    check("t6_rst_data",  q_rd_data, 128'd0);
    rst_n = 1'b1;
    drive_byte(1, 1'b1, 8'hD5, {48'h99, 32'd99});
    drive_byte(1, 1'b1, 8'h12, rand_rtc());
    drive_byte(1, 1'b1, 8'h34, rand_rtc());
    drive_byte(1, 1'b0, 8'h00, rand_rtc());
    rx_valid  = '0;
    ptp_done  = 4'b0010;
    ptp_found = 4'b0010;
    step();
    ptp_done  = '0;
    ptp_found = '0;
    repeat (5) step();
    check("t6_not_stamped", 128'(q_rd_empty), 128'(1'b1));

    // Normal operation resumes after reset
    mdl_last = 0;
    run_frame(4'b0010, 48'h1_0000_0001, 32'd999_999_999, $urandom, 1'b1, 1'b1);
    drain("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
